seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one combinational hex-to-seven-segment decoder across `NUM_DIGITS` common-cathode digits. It holds a double-buffered display value, drives the decoder's 4-bit input one digit at a time, registers the decoder's 8-bit segment pattern, and enables one digit at a time. A blanking gap between digits suppresses ghosting. It sits between the Nios/keypad value source and the display pins, with the existing decoder instantiated beside it.

---
 rtl/seven_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed scan controller for common-cathode seven-segment digits
//
// Shares one external hex-to-seven-segment decoder across NUM_DIGITS digits.
// Each digit visit is a dark BLANK interval followed by a lit SHOW interval.
// The displayed value is double-buffered: load fills the shadow buffer, and
// the active buffer changes only at the frame wrap.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   en             scan enable; low holds the scan at BLANK/digit 0, dark
//   load           one-cycle strobe capturing value/dp_mask/lz_blank to shadow
//   value          hex digits, value[3:0] is digit 0 (rightmost)
//   dp_mask        decimal point enable per digit
//   lz_blank       leading-zero blanking enable
//   dec_in         nibble to the shared decoder
//   dec_seg        decoder output {DP,G..A}; DP bit is not used
//   seg_out        registered segment drive {DP,G..A}, active-high
//   digit_en       one-hot digit enable, all-zero when dark
//   frame_done     one-cycle pulse at each scan wrap
//   pending        shadow value waiting for the next wrap

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [3:0]              dec_in,
  input  logic [7:0]              dec_seg,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_LEN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
  localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             enter_show;
  logic             leave_show;
  logic             wrap;

  // Active (displayed) and shadow (loaded) buffers
  logic [4*NUM_DIGITS-1:0] act_value, sh_value;
  logic [NUM_DIGITS-1:0]   act_dp, sh_dp;
  logic                    act_lz, sh_lz;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic                    cur_blank;

  // DP comes from dp_mask, so the decoder's own DP bit is deliberately dropped
  logic unused_dec_dp;
  assign unused_dec_dp = dec_seg[7];

  // The decoder sees the current digit for the whole BLANK interval, which is
  // its settling time before the SHOW entry edge captures dec_seg.
  assign dec_in = act_value[{idx, 2'b00} +: 4];

  // Digit i is blanked when it and every more-significant nibble are zero;
  // digit 0 always shows so a zero value still reads "0".
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (act_value[4*i +: 4] == 4'h0);
      lz_mask[i] = act_lz & upper_zero & (i != 0);
    end
  end

  assign cur_blank = lz_mask[idx];

  // State, dwell counter and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // The counter runs from 0 up to the state length minus 1, so each state
  // lasts exactly its length in clocks, including the first BLANK after reset.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CNT_ONE;
    idx_nx     = idx;
    enter_show = 1'b0;
    leave_show = 1'b0;
    wrap       = 1'b0;
    if (!en) begin
      state_nx = ST_BLANK;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx   = ST_SHOW;
            cnt_nx     = '0;
            enter_show = 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DIGIT_LAST) begin
            state_nx   = ST_BLANK;
            cnt_nx     = '0;
            leave_show = 1'b1;
            if (idx == IDX_LAST) begin
              idx_nx = '0;
              wrap   = 1'b1;
            end else begin
              idx_nx = idx + IDX_ONE;
            end
          end
        end
        default: begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Registered display drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out    <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (!en || leave_show) begin
        seg_out  <= '0;
        digit_en <= '0;
      end else if (enter_show) begin
        digit_en <= DIGIT_ONE << idx;
        seg_out  <= {act_dp[idx], cur_blank ? 7'h00 : dec_seg[6:0]};
      end
    end
  end

  // Double buffer. A load on the wrap edge commits the previous shadow and
  // captures the new data, so pending stays set for the following wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_value <= '0;
      act_dp    <= '0;
      act_lz    <= 1'b0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (wrap && pending) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_lz    <= sh_lz;
      end
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp_mask;
        sh_lz    <= lz_blank;
        pending  <= 1'b1;
      end else if (wrap) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - bench for seven_seg_scan_ctrl with a time-position display model
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int PER   = DC + BC;
  localparam int FRAME = ND * PER;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  dec_in;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_done;
  logic        pending;
  logic        junk = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Display model: edges since the scan (re)started, plus the two buffers
  int          m_k = 0;
  logic [15:0] m_act = 0, m_sh = 0;
  logic [3:0]  m_dp_a = 0, m_dp_s = 0;
  logic        m_lz_a = 0, m_lz_s = 0;
  logic        m_pend = 0;
  logic [7:0]  seen [ND];

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  // Stand-in for the shared decoder; bit 7 carries noise the DUT must ignore
  assign dec_seg = {junk, hex7(dec_in)};

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .value(value),
    .dp_mask(dp_mask), .lz_blank(lz_blank), .dec_in(dec_in), .dec_seg(dec_seg),
    .seg_out(seg_out), .digit_en(digit_en), .frame_done(frame_done), .pending(pending)
  );

  // One clock: advance the model at the edge, compare outputs 1 ns later,
  // return 2 ns after the edge so callers change inputs away from it.
  task automatic cyc(input int n);
    int m, d;
    logic lit, blk, e_fd;
    logic [3:0] nib, e_den;
    logic [7:0] e_seg;
    repeat (n) begin
      @(posedge clk);
      if (!reset_n) begin
        m_k = 0; m_act = 0; m_sh = 0; m_dp_a = 0; m_dp_s = 0;
        m_lz_a = 0; m_lz_s = 0; m_pend = 0;
      end else begin
        if (en) begin
          m_k++;
          if (m_k % FRAME == 0 && m_pend) begin
            m_act = m_sh; m_dp_a = m_dp_s; m_lz_a = m_lz_s; m_pend = 0;
          end
        end else begin
          m_k = 0;
        end
        if (load) begin
          m_sh = value; m_dp_s = dp_mask; m_lz_s = lz_blank; m_pend = 1;
        end
      end
      #1;
      m     = m_k % PER;
      d     = (m_k / PER) % ND;
      lit   = (m >= BC);
      nib   = m_act[4*d +: 4];
      blk   = m_lz_a && (d != 0) && ((m_act >> (4*d)) == 16'h0);
      e_seg = lit ? {m_dp_a[d], blk ? 7'h00 : hex7(nib)} : 8'h00;
      e_den = lit ? 4'(1 << d) : 4'h0;
      e_fd  = (m_k > 0) && (m_k % FRAME == 0);
      n_cmp += 7;
      if (digit_en !== e_den) begin n_bad++; $display("FAIL cyc_digit_en t=%0t got %b expected %b", $time, digit_en, e_den); end
      if (seg_out !== e_seg) begin n_bad++; $display("FAIL cyc_seg_out t=%0t got %h expected %h", $time, seg_out, e_seg); end
      if (frame_done !== e_fd) begin n_bad++; $display("FAIL cyc_frame_done t=%0t got %b expected %b", $time, frame_done, e_fd); end
      if (pending !== m_pend) begin n_bad++; $display("FAIL cyc_pending t=%0t got %b expected %b", $time, pending, m_pend); end
      if (dec_in !== nib) begin n_bad++; $display("FAIL cyc_dec_in t=%0t got %h expected %h", $time, dec_in, nib); end
      if (!$onehot0(digit_en)) begin n_bad++; $display("FAIL inv_onehot t=%0t got %b expected one-hot or zero", $time, digit_en); end
      if (digit_en == 4'h0 && seg_out !== 8'h00) begin n_bad++; $display("FAIL inv_dark_seg t=%0t got %h expected 00", $time, seg_out); end
      for (int i = 0; i < ND; i++) if (digit_en == 4'(1 << i)) seen[i] = seg_out;
      #1;
      junk = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < ND; i++) seen[i] = 8'hxx;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1);
      if (frame_done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value = v; dp_mask = dp; lz_blank = lz; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; load = 1'b0;
    #1;
    n_cmp++;
    if ({seg_out, digit_en, frame_done, pending, dec_in} !== 18'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h expected 0", {seg_out, digit_en, frame_done, pending, dec_in});
    end
    cyc(3);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    logic [7:0] exp_seg [ND];
    int first, gap;
    bit ok;
    exp_seg[0] = 8'h66; exp_seg[1] = 8'h4F; exp_seg[2] = 8'h5B; exp_seg[3] = 8'h06;
    en = 1'b1;
    first = -1;
    do_load(16'h1234, 4'h0, 1'b0);
    if (digit_en != 0) first = 1;
    for (int n = 2; n <= 20; n++) begin
      cyc(1);
      if (digit_en != 0 && first < 0) first = n;
    end
    n_cmp++;
    if (first != BC) begin n_bad++; $display("FAIL basic_first_lit got edge %0d expected %0d", first, BC); end
    wait_frame(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_wrap got timeout expected frame_done"); end
    clear_seen();
    gap = 0;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1); gap++;
      if (frame_done === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok || gap != FRAME) begin n_bad++; $display("FAIL basic_frame_period got %0d expected %0d", gap, FRAME); end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (seen[i] !== exp_seg[i]) begin n_bad++; $display("FAIL basic_digit%0d got %h expected %h", i, seen[i], exp_seg[i]); end
    end
  endtask

  task automatic test_lz_blank();
    logic [7:0] exp_seg [ND];
    bit ok;
    do_load(16'h0050, 4'b0100, 1'b1);
    wait_frame(ok);
    clear_seen();
    cyc(FRAME);
    exp_seg[0] = 8'h3F; exp_seg[1] = 8'h6D; exp_seg[2] = 8'h80; exp_seg[3] = 8'h00;
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (!ok || seen[i] !== exp_seg[i]) begin n_bad++; $display("FAIL lz_0050_digit%0d got %h expected %h", i, seen[i], exp_seg[i]); end
    end
    do_load(16'h0000, 4'b0000, 1'b1);
    wait_frame(ok);
    clear_seen();
    cyc(FRAME);
    exp_seg[0] = 8'h3F; exp_seg[1] = 8'h00; exp_seg[2] = 8'h00; exp_seg[3] = 8'h00;
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (!ok || seen[i] !== exp_seg[i]) begin n_bad++; $display("FAIL lz_0000_digit%0d got %h expected %h", i, seen[i], exp_seg[i]); end
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    do_load(16'hAAAA, 4'h0, 1'b0);
    wait_frame(ok);
    cyc(12);
    n_cmp++;
    if (!ok || digit_en !== 4'b0010) begin n_bad++; $display("FAIL tear_at_digit1 got %b expected 0010", digit_en); end
    clear_seen();
    do_load(16'hBBBB, 4'h0, 1'b0);
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL tear_pending_set got %b expected 1", pending); end
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc(1);
      if (frame_done === 1'b1) begin ok = 1; break; end
      n_cmp++;
      if (pending !== 1'b1) begin n_bad++; $display("FAIL tear_pending_hold got %b expected 1", pending); end
    end
    n_cmp++;
    if (!ok || pending !== 1'b0) begin n_bad++; $display("FAIL tear_pending_clear got %b expected 0", pending); end
    for (int i = 1; i < ND; i++) begin
      n_cmp++;
      if (seen[i] !== 8'h77) begin n_bad++; $display("FAIL tear_old_digit%0d got %h expected 77", i, seen[i]); end
    end
    clear_seen();
    cyc(FRAME);
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (seen[i] !== 8'h7C) begin n_bad++; $display("FAIL tear_new_digit%0d got %h expected 7c", i, seen[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    value = 16'h1111; dp_mask = 4'h0; lz_blank = 1'b0; load = 1'b1;
    cyc(1);
    value = 16'h2222;
    cyc(1);
    load = 1'b0;
    wait_frame(ok);
    clear_seen();
    cyc(FRAME);
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (!ok || seen[i] !== 8'h5B) begin n_bad++; $display("FAIL b2b_newest_digit%0d got %h expected 5b", i, seen[i]); end
    end
    cyc(20);
    do_load(16'h3333, 4'h0, 1'b0);
    cyc(18);
    do_load(16'h4444, 4'h0, 1'b0);
    n_cmp++;
    if (frame_done !== 1'b1 || pending !== 1'b1) begin
      n_bad++; $display("FAIL b2b_wrap_load got fd=%b pend=%b expected fd=1 pend=1", frame_done, pending);
    end
    clear_seen();
    cyc(FRAME);
    n_cmp++;
    if (pending !== 1'b0) begin n_bad++; $display("FAIL b2b_second_commit got %b expected 0", pending); end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (seen[i] !== 8'h4F) begin n_bad++; $display("FAIL b2b_wrap_digit%0d got %h expected 4f", i, seen[i]); end
    end
    clear_seen();
    cyc(FRAME);
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (seen[i] !== 8'h66) begin n_bad++; $display("FAIL b2b_final_digit%0d got %h expected 66", i, seen[i]); end
    end
  endtask

  task automatic test_enable();
    bit ok;
    int first;
    wait_frame(ok);
    cyc(22);
    n_cmp++;
    if (!ok || digit_en !== 4'b0100) begin n_bad++; $display("FAIL en_at_digit2 got %b expected 0100", digit_en); end
    en = 1'b0;
    cyc(1);
    n_cmp++;
    if (digit_en !== 4'h0 || seg_out !== 8'h00) begin
      n_bad++; $display("FAIL en_dark got %b/%h expected 0000/00", digit_en, seg_out);
    end
    do_load(16'h5555, 4'h0, 1'b0);
    n_cmp++;
    if (pending !== 1'b1) begin n_bad++; $display("FAIL en_low_load got %b expected 1", pending); end
    cyc(3);
    en = 1'b1;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      if (digit_en != 0 && first < 0) begin
        first = n;
        n_cmp++;
        if (digit_en !== 4'b0001) begin n_bad++; $display("FAIL en_restart_digit got %b expected 0001", digit_en); end
      end
    end
    n_cmp++;
    if (first != BC) begin n_bad++; $display("FAIL en_restart_edge got %0d expected %0d", first, BC); end
    wait_frame(ok);
    clear_seen();
    cyc(FRAME);
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (!ok || seen[i] !== 8'h6D) begin n_bad++; $display("FAIL en_commit_digit%0d got %h expected 6d", i, seen[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 1500; c++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 2) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      load = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < ND; i++) v[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      value = v;
      dp_mask = 4'($urandom_range(0, 15));
      lz_blank = 1'($urandom_range(0, 1));
      cyc(1);
    end
    load = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      cyc(1);
      if (digit_en != 0) begin ok = 1; break; end
    end
    do_load(16'h9876, 4'hF, 1'b0);
    n_cmp++;
    if (!ok || pending !== 1'b1 || digit_en == 4'h0) begin
      n_bad++; $display("FAIL rstmid_setup got pend=%b den=%b expected pend=1 lit", pending, digit_en);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg_out, digit_en, frame_done, pending} !== 14'h0) begin
      n_bad++; $display("FAIL rstmid_async got %h expected 0", {seg_out, digit_en, frame_done, pending});
    end
    cyc(2);
    reset_n = 1'b1;
    cyc(2 * PER);
  endtask

  initial begin
    clear_seen();
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_tear_free();
    test_back_to_back();
    test_enable();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
